// File: rtl/rob_commit_unit_if.sv
// Bundle between the commit unit and its neighbours: ROB head/pop/flush, regfile write port,
// store-buffer release handshake, fetch redirect and performance counters.
interface rob_commit_unit_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             rob_empty;
  logic [31:0]      rob_head_instr;
  logic [31:0]      rob_head_val;
  logic             rob_head_ready;
  logic             rob_pop;
  logic             rob_flush;
  logic [31:0]      rob_flush_instr;
  logic             rf_wEn;
  logic [4:0]       rf_addr;
  logic [31:0]      rf_data;
  logic             st_valid;
  logic [31:0]      st_instr;
  logic             st_ready;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] retired_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  stall, rob_empty, rob_head_instr, rob_head_val, rob_head_ready, st_ready,
    output rob_pop, rob_flush, rob_flush_instr, rf_wEn, rf_addr, rf_data,
           st_valid, st_instr, redirect_valid, redirect_pc, retired_count, flush_count
  );

  modport slave (
    output stall, rob_empty, rob_head_instr, rob_head_val, rob_head_ready, st_ready,
    input  rob_pop, rob_flush, rob_flush_instr, rf_wEn, rf_addr, rf_data,
           st_valid, st_instr, redirect_valid, redirect_pc, retired_count, flush_count
  );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order retirement of the ROB head: register writeback, store release or mispredict flush.
// Every output is registered; pulses last exactly one cycle per commit.
module rob_commit_unit #(
  parameter int CNT_W    = 32,
  parameter bit R0_WRITE = 1'b0
) (
  input logic               clock,
  input logic               reset,
  rob_commit_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, COMMIT, STORE_REQ, SETTLE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic [31:0]      head_instr, head_val;
  logic             eligible;
  logic [31:0]      commit_instr, commit_val;
  logic [4:0]       commit_op, commit_rd;
  logic             is_wb, is_store, is_ctrl, mispredict;
  logic             pop_d, flush_d, wen_d, redir_d, st_valid_d;
  logic [31:0]      flush_instr_d, rf_data_d, st_instr_d, redirect_pc_d;
  logic [4:0]       rf_addr_d;
  logic [CNT_W-1:0] retired_d, flush_cnt_d;

  assign eligible = !bus.stall && !bus.rob_empty && bus.rob_head_ready &&
                    (bus.rob_head_instr != 32'd0);

  // In IDLE the live head is decoded; afterwards the sampled copy is used so a
  // head_ready drop or head change during a store handshake has no effect.
  assign commit_instr = (state == IDLE) ? bus.rob_head_instr : head_instr;
  assign commit_val   = (state == IDLE) ? bus.rob_head_val   : head_val;
  assign commit_op    = commit_instr[31:27];
  assign commit_rd    = commit_instr[26:22];
  assign is_wb        = commit_op inside {5'b00000, 5'b00101, 5'b01000, 5'b00011};
  assign is_store     = (commit_op == 5'b00111);
  assign is_ctrl      = commit_op inside {5'b00001, 5'b00010, 5'b00100, 5'b00110};
  assign mispredict   = is_ctrl && commit_val[31];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_instr <= 32'd0;
      head_val   <= 32'd0;
    end else if (state == IDLE && eligible) begin
      head_instr <= bus.rob_head_instr;
      head_val   <= bus.rob_head_val;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (eligible) state_next = is_store ? STORE_REQ : COMMIT;
      COMMIT:    state_next = mispredict ? SETTLE : IDLE;
      STORE_REQ: if (bus.st_ready) state_next = COMMIT;
      SETTLE:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; data outputs hold unless a new commit loads them.
  always_comb begin
    pop_d         = 1'b0;
    flush_d       = 1'b0;
    wen_d         = 1'b0;
    redir_d       = 1'b0;
    st_valid_d    = 1'b0;
    flush_instr_d = bus.rob_flush_instr;
    rf_addr_d     = bus.rf_addr;
    rf_data_d     = bus.rf_data;
    st_instr_d    = bus.st_instr;
    redirect_pc_d = bus.redirect_pc;
    retired_d     = bus.retired_count;
    flush_cnt_d   = bus.flush_count;
    if (state_next == STORE_REQ) begin
      st_valid_d = 1'b1;
      st_instr_d = commit_instr;
    end
    if (state_next == COMMIT) begin
      pop_d     = 1'b1;
      retired_d = bus.retired_count + CNT_ONE;
      if (is_wb) begin
        rf_addr_d = (commit_op == 5'b00011) ? 5'd31 : commit_rd;
        rf_data_d = commit_val;
        wen_d     = (rf_addr_d != 5'd0) || R0_WRITE;
      end
      if (mispredict) begin
        flush_d       = 1'b1;
        redir_d       = 1'b1;
        flush_instr_d = commit_instr;
        redirect_pc_d = {1'b0, commit_val[30:0]};
        flush_cnt_d   = bus.flush_count + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.rob_pop         <= 1'b0;
      bus.rob_flush       <= 1'b0;
      bus.rob_flush_instr <= 32'd0;
      bus.rf_wEn          <= 1'b0;
      bus.rf_addr         <= 5'd0;
      bus.rf_data         <= 32'd0;
      bus.st_valid        <= 1'b0;
      bus.st_instr        <= 32'd0;
      bus.redirect_valid  <= 1'b0;
      bus.redirect_pc     <= 32'd0;
      bus.retired_count   <= '0;
      bus.flush_count     <= '0;
    end else begin
      bus.rob_pop         <= pop_d;
      bus.rob_flush       <= flush_d;
      bus.rob_flush_instr <= flush_instr_d;
      bus.rf_wEn          <= wen_d;
      bus.rf_addr         <= rf_addr_d;
      bus.rf_data         <= rf_data_d;
      bus.st_valid        <= st_valid_d;
      bus.st_instr        <= st_instr_d;
      bus.redirect_valid  <= redir_d;
      bus.redirect_pc     <= redirect_pc_d;
      bus.retired_count   <= retired_d;
      bus.flush_count     <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: a queue-based ROB model feeds the head, a scoreboard of expected
// retirements is checked by an independent monitor each time the DUT pops.
module tb_rob_commit_unit;
  logic clock;
  logic reset;

  rob_commit_unit_if #(.CNT_W(32)) bus ();

  rob_commit_unit #(.CNT_W(32), .R0_WRITE(1'b0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] val;
  } rob_ent_t;

  typedef struct {
    logic [31:0] instr;
    bit          wen;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          flush;
    logic [31:0] pc;
    bit          is_store;
  } exp_t;

  rob_ent_t    rob_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ret_model = 0;
  logic [31:0] flush_model = 0;
  int          st_hi_cnt = 0;
  int          pop_total = 0;
  bit          prev_pop = 0;
  bit          model_flushed = 0;
  bit          rand_mode = 0;
  bit          forced_stall = 0;
  bit          forced_st_ready = 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: condition not reached within its cycle budget", name);
  endtask

  // What retiring one instruction must look like, straight from the decode rules.
  function automatic exp_t refModel(input logic [31:0] instr, input logic [31:0] val);
    exp_t       e;
    logic [4:0] op = instr[31:27];
    logic [4:0] rd = instr[26:22];
    e.instr = instr; e.wen = 0; e.addr = 0; e.data = 0; e.flush = 0; e.pc = 0; e.is_store = 0;
    case (op)
      5'd0, 5'd5, 5'd8: begin e.wen = (rd != 5'd0); e.addr = rd; e.data = val; end
      5'd3:             begin e.wen = 1; e.addr = 5'd31; e.data = val; end
      5'd7:             e.is_store = 1;
      5'd1, 5'd2, 5'd4, 5'd6:
        if (val[31]) begin e.flush = 1; e.pc = {1'b0, val[30:0]}; end
      default: ;
    endcase
    return e;
  endfunction

  // Entries behind a mispredicted branch enter the ROB but are flushed, so never expected.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] val);
    rob_ent_t r;
    exp_t     e;
    r.instr = instr;
    r.val   = val;
    rob_q.push_back(r);
    if (!model_flushed) begin
      e = refModel(instr, val);
      exp_q.push_back(e);
      if (e.flush) model_flushed = 1;
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((rob_q.size() != 0 || exp_q.size() != 0 || bus.st_valid) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) failNow(name);
    repeat (2) @(negedge clock);
    model_flushed = 0;
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [21:0] low;
    case ($urandom_range(0, 11))
      0: op = 5'd0;  1: op = 5'd5;  2: op = 5'd8;  3: op = 5'd3;
      4: op = 5'd7;  5: op = 5'd1;  6: op = 5'd2;  7: op = 5'd4;
      8: op = 5'd6;  default: op = 5'($urandom_range(9, 31));
    endcase
    rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    low = 22'($urandom) | 22'd1;
    return {op, rd, low};
  endfunction

  // ROB model: pops/flushes seen on the previous negedge, then presents the new head.
  initial begin
    bit p, f;
    bus.stall = 0; bus.rob_empty = 1; bus.rob_head_instr = 0;
    bus.rob_head_val = 0; bus.rob_head_ready = 0; bus.st_ready = 0;
    forever begin
      @(negedge clock);
      p = bus.rob_pop;
      f = bus.rob_flush;
      @(posedge clock);
      #1;
      if (p && rob_q.size() > 0) void'(rob_q.pop_front());
      if (f) rob_q.delete();
      bus.rob_empty      = (rob_q.size() == 0);
      bus.rob_head_instr = (rob_q.size() == 0) ? 32'd0 : rob_q[0].instr;
      bus.rob_head_val   = (rob_q.size() == 0) ? 32'd0 : rob_q[0].val;
      bus.rob_head_ready = (rob_q.size() != 0) && (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.stall          = rand_mode ? ($urandom_range(0, 4) == 0) : forced_stall;
      bus.st_ready       = rand_mode ? ($urandom_range(0, 2) == 0) : forced_st_ready;
    end
  end

  // Monitor: compares every retirement against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (bus.rob_pop) begin
          checkOutput("pop_single_cycle", 32'(prev_pop), 32'd0);
          if (exp_q.size() == 0) begin
            failNow("pop_without_expected_commit");
          end else begin
            e = exp_q.pop_front();
            ret_model++;
            checkOutput("rf_wEn", 32'(bus.rf_wEn), 32'(e.wen));
            if (e.wen) begin
              checkOutput("rf_addr", 32'(bus.rf_addr), 32'(e.addr));
              checkOutput("rf_data", bus.rf_data, e.data);
            end
            checkOutput("rob_flush", 32'(bus.rob_flush), 32'(e.flush));
            checkOutput("redirect_valid", 32'(bus.redirect_valid), 32'(e.flush));
            if (e.flush) begin
              flush_model++;
              checkOutput("redirect_pc", bus.redirect_pc, e.pc);
              checkOutput("rob_flush_instr", bus.rob_flush_instr, e.instr);
            end
            checkOutput("retired_count", bus.retired_count, ret_model);
            checkOutput("flush_count", bus.flush_count, flush_model);
          end
        end else begin
          checkOutput("strobes_without_pop",
                      {29'd0, bus.rf_wEn, bus.rob_flush, bus.redirect_valid}, 32'd0);
        end
        if (bus.st_valid) begin
          st_hi_cnt++;
          if (exp_q.size() == 0) begin
            failNow("st_valid_without_entry");
          end else begin
            checkOutput("st_instr", bus.st_instr, exp_q[0].instr);
            checkOutput("st_valid_on_store", 32'(exp_q[0].is_store), 32'd1);
          end
        end
        if (bus.rob_pop) pop_total++;
        prev_pop = bus.rob_pop;
      end else begin
        prev_pop = 0;
      end
    end
  end

  initial begin
    int n;
    int p0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_rob_pop", 32'(bus.rob_pop), 32'd0);
    checkOutput("reset_st_valid", 32'(bus.st_valid), 32'd0);
    checkOutput("reset_rf_wEn", 32'(bus.rf_wEn), 32'd0);
    checkOutput("reset_retired", bus.retired_count, 32'd0);
    checkOutput("reset_flushes", bus.flush_count, 32'd0);
    checkOutput("reset_redirect", 32'(bus.redirect_valid), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    applyStimulus(32'h00C00000, 32'h0000_1234);
    waitDrain("alu_drain");
    checkOutput("rf_addr_hold", 32'(bus.rf_addr), 32'd3);
    checkOutput("rf_data_hold", bus.rf_data, 32'h0000_1234);

    applyStimulus(32'h00000005, 32'h0000_DEAD);
    waitDrain("r0_drain");

    applyStimulus(32'h10000001, 32'h8000_0040);
    applyStimulus(32'h00C00001, 32'h0000_0005);
    waitDrain("branch_drain");
    checkOutput("redirect_pc_hold", bus.redirect_pc, 32'h0000_0040);

    // Store release with st_ready held low for the first five request cycles.
    forced_st_ready = 0;
    repeat (2) @(negedge clock);
    st_hi_cnt = 0;
    applyStimulus(32'h38000011, 32'h0000_00AA);
    n = 0;
    while (!bus.st_valid && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) failNow("store_request_start");
    repeat (4) @(negedge clock);
    forced_st_ready = 1;
    @(negedge clock);
    forced_st_ready = 0;
    @(negedge clock);
    checkOutput("store_pop_after_accept", 32'(bus.rob_pop), 32'd1);
    checkOutput("store_valid_dropped", 32'(bus.st_valid), 32'd0);
    waitDrain("store_drain");
    checkOutput("store_valid_cycles", 32'(st_hi_cnt), 32'd6);
    forced_st_ready = 1;

    forced_stall = 1;
    repeat (2) @(negedge clock);
    p0 = pop_total;
    applyStimulus(32'h01400000, 32'h0000_0077);
    repeat (6) @(negedge clock);
    checkOutput("stall_no_pop", 32'(pop_total - p0), 32'd0);
    forced_stall = 0;
    @(negedge clock);
    checkOutput("stall_release_not_early", 32'(bus.rob_pop), 32'd0);
    @(negedge clock);
    checkOutput("stall_release_commit", 32'(bus.rob_pop), 32'd1);
    waitDrain("stall_drain");

    rand_mode = 1;
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        logic [31:0] v;
        v = $urandom;
        v[31] = ($urandom_range(0, 3) == 0);
        applyStimulus(randInstr(), v);
      end
      waitDrain("random_batch_drain");
    end
    rand_mode = 0;

    // Asynchronous reset while a store release is outstanding.
    forced_st_ready = 0;
    repeat (2) @(negedge clock);
    applyStimulus(32'h38400022, 32'h0000_0099);
    n = 0;
    while (!bus.st_valid && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) failNow("reset_store_start");
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_st_valid", 32'(bus.st_valid), 32'd0);
    checkOutput("async_reset_retired", bus.retired_count, 32'd0);
    checkOutput("async_reset_flushes", bus.flush_count, 32'd0);
    checkOutput("async_reset_pop", 32'(bus.rob_pop), 32'd0);
    rob_q.delete();
    exp_q.delete();
    ret_model = 0;
    flush_model = 0;
    model_flushed = 0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("store_dropped_after_reset", 32'(bus.st_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
